// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-granular round-robin arbiter that shares one
// AXI4-Stream output among S source streams. A source that wins arbitration
// owns the output until its tlast beat transfers; the next arbitration happens
// in the idle cycle that follows, searching cyclically from the last winner + 1.
module axis_rr_arbiter #(
  parameter int S  = 4,
  parameter int N  = 1,
  parameter int IW = $clog2(S)
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic               enable,
  input  logic [S-1:0]       s_tvalid,
  output logic [S-1:0]       s_tready,
  input  logic [S*8*N-1:0]   s_tdata,
  input  logic [S-1:0]       s_tlast,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic [8*N-1:0]     m_tdata,
  output logic               m_tlast,
  output logic [IW-1:0]      m_tid,
  output logic [S-1:0]       grant,
  output logic [15:0]        beats
);

  localparam int DW = 8 * N;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [S-1:0]    grant_q, grant_d;
  logic [IW-1:0]   tid_q, tid_d;
  logic [IW-1:0]   last_q, last_d;
  logic [15:0]     beats_q, beats_d;

  logic            pick_found_s;
  logic [IW-1:0]   pick_s;
  logic            sel_valid_s;
  logic            sel_last_s;
  logic [DW-1:0]   sel_data_s;
  logic            xfer_s;

  // Source index reached by stepping 'offset' places past 'base', wrapping at S.
  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int offset);
    int sum;
    sum = (int'(base) + offset) % S;
    return IW'(sum);
  endfunction

  // Round-robin search: first requesting source after the last winner.
  always_comb begin
    pick_found_s = 1'b0;
    pick_s       = {IW{1'b0}};
    for (int k = 1; k <= S; k++) begin
      if (!pick_found_s && s_tvalid[wrap_idx(last_q, k)]) begin
        pick_found_s = 1'b1;
        pick_s       = wrap_idx(last_q, k);
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Select the granted source's tvalid/tdata/tlast.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_last_s  = 1'b0;
    sel_data_s  = {DW{1'b0}};
    for (int i = 0; i < S; i++) begin
      if (tid_q == IW'(i)) begin
        sel_valid_s = s_tvalid[i];
        sel_last_s  = s_tlast[i];
        sel_data_s  = s_tdata[i*DW +: DW];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
  end

  // Zero-latency datapath while a packet owns the output; quiet when idle.
  always_comb begin
    m_tvalid = 1'b0;
    m_tdata  = {DW{1'b0}};
    m_tlast  = 1'b0;
    s_tready = {S{1'b0}};
    if (state_q == BUSY) begin
      m_tvalid = sel_valid_s;
      m_tdata  = sel_data_s;
      m_tlast  = sel_last_s;
      s_tready = grant_q & {S{m_tready}};
    end else begin
      m_tvalid = 1'b0;
    end
  end

  assign xfer_s = (state_q == BUSY) && sel_valid_s && m_tready;

  // Next-state logic: grant between packets, count beats, release on tlast.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    tid_d   = tid_q;
    last_d  = last_q;
    beats_d = beats_q;
    case (state_q)
      IDLE: begin
        if (enable && pick_found_s) begin
          state_d = BUSY;
          grant_d = {{(S-1){1'b0}}, 1'b1} << pick_s;
          tid_d   = pick_s;
          last_d  = pick_s;
          beats_d = 16'd0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (xfer_s) begin
          if (beats_q != 16'hFFFF) begin
            beats_d = beats_q + 16'd1;
          end else begin
            beats_d = beats_q;
          end
          if (sel_last_s) begin
            state_d = IDLE;
            grant_d = {S{1'b0}};
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = {S{1'b0}};
      end
    endcase
  end

  // State registers; reset points the pointer at S-1 so source 0 wins first.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= {S{1'b0}};
      tid_q   <= {IW{1'b0}};
      last_q  <= IW'(S - 1);
      beats_q <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      tid_q   <= tid_d;
      last_q  <= last_d;
      beats_q <= beats_d;
    end
  end

  assign grant = grant_q;
  assign m_tid = tid_q;
  assign beats = beats_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb_axis_rr_arbiter: scoreboard bench. Source queues hold packets; a
// packet-level round-robin model predicts grants and pushes expected beats,
// and an independent monitor pops them whenever the output transfers.
module tb_axis_rr_arbiter;
  localparam int S  = 4;
  localparam int N  = 1;
  localparam int IW = 2;
  localparam int DW = 8;

  logic            aclk = 1'b0;
  logic            areset;
  logic            enable;
  logic [S-1:0]    s_tvalid, s_tready, s_tlast, grant;
  logic [S*DW-1:0] s_tdata;
  logic            m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]   m_tdata;
  logic [IW-1:0]   m_tid;
  logic [15:0]     beats;

  always #5 aclk = ~aclk;

  axis_rr_arbiter #(.S(S), .N(N)) dut (
    .aclk(aclk), .areset(areset), .enable(enable),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tid(m_tid), .grant(grant), .beats(beats)
  );

  typedef struct {
    logic [3:0] gap;
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         src;
    int         len;
  } exp_t;

  beat_t sq[S][$];
  exp_t  exp_q[$];
  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;
  int    tready_mode = 0;
  int    xfer_cnt = 0;
  int    stall_cnt = 0;
  int    glog[$];
  int    gtime[$];
  bit    loaded[S];
  int    cur_gap[S];

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < S; i++) if (sq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Source and sink driver: pops beats that transferred, applies per-beat gaps.
  initial begin
    logic [S-1:0] fire;
    s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b0;
    forever begin
      @(negedge aclk);
      fire = s_tvalid & s_tready;
      @(posedge aclk);
      #1;
      for (int i = 0; i < S; i++) begin
        if (fire[i] && sq[i].size() > 0) begin
          void'(sq[i].pop_front());
          loaded[i] = 1'b0;
        end
        if (sq[i].size() > 0 && !loaded[i]) begin
          cur_gap[i] = int'(sq[i][0].gap);
          loaded[i]  = 1'b1;
        end else if (loaded[i] && cur_gap[i] > 0) begin
          cur_gap[i]--;
        end
        if (sq[i].size() > 0 && loaded[i] && cur_gap[i] == 0) begin
          s_tvalid[i] = 1'b1;
          s_tdata[i*DW +: DW] = sq[i][0].data;
          s_tlast[i] = sq[i][0].last;
        end else begin
          s_tvalid[i] = 1'b0;
          s_tdata[i*DW +: DW] = 8'h00;
          s_tlast[i] = 1'b0;
        end
      end
      case (tready_mode)
        0: m_tready = 1'b1;
        1: m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Packet-level reference: who owns the output, and which beats must appear.
  initial begin
    bit           m_busy;
    int           m_owner, m_last, len;
    bit           found;
    logic [S-1:0] eg;
    exp_t         e;
    m_busy = 1'b0; m_owner = 0; m_last = S - 1;
    forever begin
      @(negedge aclk);
      if (areset) begin
        m_busy = 1'b0; m_last = S - 1;
      end else begin
        eg = '0;
        if (m_busy) eg[m_owner] = 1'b1;
        check("grant", 32'(grant), 32'(eg));
        if (m_busy) begin
          check("m_tvalid", 32'(m_tvalid), 32'(s_tvalid[m_owner]));
          if (s_tvalid[m_owner] && m_tready && s_tlast[m_owner]) m_busy = 1'b0;
        end else begin
          check("idle_outputs", 32'({m_tvalid, m_tlast, m_tdata}), 32'd0);
          if (enable && s_tvalid != '0) begin
            found = 1'b0;
            for (int k = 1; k <= S; k++) begin
              if (!found && s_tvalid[(m_last + k) % S]) begin
                found = 1'b1;
                m_owner = (m_last + k) % S;
              end
            end
            m_last = m_owner;
            m_busy = 1'b1;
            len = 0;
            for (int j = 0; j < sq[m_owner].size(); j++) begin
              len++;
              if (sq[m_owner][j].last) break;
            end
            for (int j = 0; j < len; j++) begin
              e.data = sq[m_owner][j].data;
              e.last = sq[m_owner][j].last;
              e.src  = m_owner;
              e.len  = len;
              exp_q.push_back(e);
            end
          end
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every output transfer.
  initial begin
    logic [S-1:0] prev_grant;
    bit           pend;
    int           pend_beats;
    exp_t         e;
    prev_grant = '0; pend = 1'b0; pend_beats = 0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        pend = 1'b0; prev_grant = '0;
      end else begin
        if (pend) begin
          check("beats", 32'(beats), 32'(pend_beats));
          pend = 1'b0;
        end
        check("nongranted_tready", 32'(s_tready & ~grant), 32'd0);
        if (grant != '0 && prev_grant == '0) begin
          glog.push_back(int'(m_tid));
          gtime.push_back(cyc);
          check("grant_matches_tid", 32'(grant), 32'(1) << m_tid);
        end
        if (grant != '0 && !m_tvalid) stall_cnt++;
        if (m_tvalid && m_tready) begin
          xfer_cnt++;
          check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("m_tdata", 32'(m_tdata), 32'(e.data));
            check("m_tlast", 32'(m_tlast), 32'(e.last));
            check("m_tid", 32'(m_tid), 32'(e.src));
            if (e.last) begin
              pend = 1'b1;
              pend_beats = e.len;
            end
          end
        end
        prev_grant = grant;
      end
    end
  end

  task automatic do_reset();
    @(posedge aclk);
    #3 areset = 1'b1;
    #1;
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_beats", 32'(beats), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_m_tid", 32'(m_tid), 32'd0);
    for (int i = 0; i < S; i++) begin
      sq[i].delete();
      loaded[i] = 1'b0;
    end
    exp_q.delete();
    glog.delete();
    gtime.delete();
    repeat (2) @(posedge aclk);
    #3 areset = 1'b0;
  endtask

  task automatic load_pkt(input int src, input int len, input int gap_max,
                          input int gap_beat, input int gap_val);
    beat_t b;
    for (int j = 0; j < len; j++) begin
      b.data = 8'($urandom);
      b.last = (j == len - 1);
      b.gap  = (gap_max > 0) ? 4'($urandom_range(0, gap_max)) : 4'd0;
      if (j == gap_beat) b.gap = 4'(gap_val);
      sq[src].push_back(b);
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (n < budget && !(all_empty() && exp_q.size() == 0 && grant == '0)) begin
      @(posedge aclk);
      #2;
      n++;
    end
    check("drain_in_budget", 32'(n < budget), 32'd1);
    repeat (2) @(posedge aclk);
    #2;
  endtask

  task automatic wait_xfers(input int target, input int budget);
    int n;
    n = 0;
    while (n < budget && xfer_cnt < target) begin
      @(posedge aclk);
      #2;
      n++;
    end
    check("xfers_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int exp_order[5];
    exp_order[0] = 0; exp_order[1] = 1; exp_order[2] = 2; exp_order[3] = 3; exp_order[4] = 0;
    areset = 1'b1;
    enable = 1'b1;
    tready_mode = 0;

    // All sources request, 2-beat packets: order 0,1,2,3,0 with wrap.
    do_reset();
    load_pkt(0, 2, 0, -1, 0); load_pkt(0, 2, 0, -1, 0);
    for (int i = 1; i < S; i++) load_pkt(i, 2, 0, -1, 0);
    wait_drain(200);
    check("order_count", 32'(glog.size()), 32'd5);
    for (int k = 0; k < glog.size() && k < 5; k++) check("order", 32'(glog[k]), 32'(exp_order[k]));
    for (int k = 1; k < gtime.size(); k++) check("two_beat_period", 32'(gtime[k] - gtime[k-1]), 32'd3);

    // Only source 2, back-to-back 3-beat packets: period 4.
    do_reset();
    for (int p = 0; p < 3; p++) load_pkt(2, 3, 0, -1, 0);
    wait_drain(200);
    check("src2_pkts", 32'(gtime.size()), 32'd3);
    for (int k = 1; k < gtime.size(); k++) check("src2_period", 32'(gtime[k] - gtime[k-1]), 32'd4);
    for (int k = 0; k < glog.size(); k++) check("src2_tid", 32'(glog[k]), 32'd2);

    // Source 1 stalls 3 cycles mid-packet while source 3 waits.
    do_reset();
    stall_cnt = 0;
    load_pkt(1, 4, 0, 1, 3);
    load_pkt(3, 2, 0, -1, 0);
    wait_drain(200);
    check("stall_cycles", 32'(stall_cnt), 32'd3);
    check("stall_first_grant", 32'(glog.size() > 0 ? glog[0] : -1), 32'd1);

    // m_tready toggling during a 4-beat packet.
    do_reset();
    tready_mode = 1;
    xfer_cnt = 0;
    load_pkt(0, 4, 0, -1, 0);
    wait_drain(200);
    check("toggle_xfers", 32'(xfer_cnt), 32'd4);
    tready_mode = 0;

    // enable dropped during beat 2 of a 5-beat packet from source 0.
    do_reset();
    xfer_cnt = 0;
    load_pkt(0, 5, 0, -1, 0);
    load_pkt(0, 2, 0, -1, 0);
    for (int i = 1; i < S; i++) load_pkt(i, 2, 0, -1, 0);
    wait_xfers(1, 50);
    enable = 1'b0;
    wait_xfers(5, 50);
    repeat (5) @(posedge aclk);
    #2;
    check("disabled_grant", 32'(grant), 32'd0);
    check("disabled_requests", 32'(s_tvalid), 32'hF);
    check("disabled_beats", 32'(beats), 32'd5);
    glog.delete();
    enable = 1'b1;
    wait_drain(200);
    check("reenable_first", 32'(glog.size() > 0 ? glog[0] : -1), 32'd1);

    // areset mid-packet from source 3, then all request: source 0 first.
    do_reset();
    xfer_cnt = 0;
    load_pkt(3, 6, 0, -1, 0);
    wait_xfers(2, 50);
    do_reset();
    for (int i = 0; i < S; i++) load_pkt(i, 1, 0, -1, 0);
    wait_drain(200);
    check("post_reset_first", 32'(glog.size() > 0 ? glog[0] : -1), 32'd0);

    // Randomized traffic: random lengths, gaps, tready and enable.
    do_reset();
    tready_mode = 2;
    for (int r = 0; r < 60; r++) begin
      load_pkt(int'($urandom_range(0, S - 1)), int'($urandom_range(1, 6)), 2, -1, 0);
      enable = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 8)) @(posedge aclk);
      #2;
    end
    enable = 1'b1;
    tready_mode = 0;
    wait_drain(3000);
    check("random_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/axis_rr_arbiter.md
Name: axis_rr_arbiter

Overview:
- Packet-granular round-robin arbiter: shares one AXI4-Stream output (e.g. the sink of a test-pattern generator) among S source streams.
- Arbitration happens only between packets. Once a source is granted, it owns the output until its tlast beat transfers.
- Sits between multiple AXIS producers (pattern generators, DMA readers) and a single AXIS consumer.

Parameters:
- S, 4, number of requesting source streams (2..16)
- N, 1, tdata width in bytes
- IW, $clog2(S), width of the m_tid grant-index output (derived; do not override)

Ports:
- aclk  input  1  clock; all logic on rising edge
- areset  input  1  asynchronous, active-high reset
- enable  input  1  when 0, no new grant is issued; a packet in flight still completes
- s_tvalid  input  S  per-source tvalid
- s_tready  output  S  per-source tready
- s_tdata  input  S*8*N  per-source tdata; source i occupies bits [i*8N +: 8N]
- s_tlast  input  S  per-source tlast
- m_tvalid  output  1  output tvalid
- m_tready  input  1  output tready
- m_tdata  output  8*N  output tdata
- m_tlast  output  1  output tlast
- m_tid  output  IW  index of the granted source, driven as tid
- grant  output  S  one-hot current grant; all zeros when idle
- beats  output  16  beats transferred in the current packet; saturates at 16'hFFFF

Behaviour:
- Reset: while areset=1, all of the following are forced, regardless of clock:
  - state=IDLE, grant=0, m_tid=0, beats=0, s_tready=0, m_tvalid=0
  - last-grant pointer = S-1, so source 0 has highest priority first after reset
- State IDLE:
  - m_tvalid=0 and s_tready=0.
  - If enable=1 and |s_tvalid, pick the first i with s_tvalid[i]=1, searching cyclically from (last+1) mod S.
  - Register grant=1<<i, m_tid=i, last=i, beats=0; next state=BUSY.
  - Arbitration latency: one cycle from tvalid seen to grant asserted.
- State BUSY, granted source g:
  - Combinational datapath: m_tvalid=s_tvalid[g], m_tdata=s_tdata[g], m_tlast=s_tlast[g].
  - s_tready[g]=m_tready; all other s_tready bits are 0.
  - Zero added latency on the datapath.
  - Transfer = m_tvalid & m_tready. On each transfer, beats increments and saturates at 16'hFFFF.
  - A transfer with m_tlast=1 clears grant and returns to IDLE next cycle. This leaves a mandatory one-cycle bubble between packets.
  - The beats value is held until the next grant.
- Fairness:
  - The pointer advances only on grant, so a continuously requesting source waits at most S-1 packets.
  - A deasserted request is skipped with no penalty.
- enable=0 during BUSY: no effect until the packet ends; afterwards the block stays IDLE.
- Source tvalid drops mid-packet: the grant is held and m_tvalid=0. There is no timeout; the packet owns the output until tlast.
- Non-granted sources: their tvalid/tdata are ignored and no data is dropped; they hold their data per the AXIS rule.
- Outputs in IDLE:
  - m_tdata and m_tlast drive 0.
  - m_tid and beats hold their last registered values.
- Mid-packet areset:
  - The packet is aborted and the output drops tvalid immediately.
  - The source is responsible for re-sending after reset.
- S=2 boundary: the pointer toggles between 0 and 1, and the wrap S-1 -> 0 must be exercised.

Test Plan:
- Reset, then s_tvalid=4'b1111, each source sends a 2-beat packet with m_tready=1 -> grant order 0,1,2,3,0. Each packet has 2 transfers, a 1-cycle bubble follows each, and beats=2 after each packet.
- Only source 2 valid, sending 3-beat packets back to back -> grant=4'b0100 every time, m_tid=2, period 4 cycles (3 beats + 1 bubble).
- Source 1 granted, s_tvalid[1] dropped for 3 cycles mid-packet while source 3 is valid -> m_tvalid=0 for those cycles, grant stays 4'b0010, and s_tready[3]=0 throughout.
- m_tready toggled 1,0,1,0 during a 4-beat packet -> exactly 4 transfers, m_tdata matches source beats in order, and beats=4.
- enable=0 asserted during beat 2 of a 5-beat packet from source 0 -> packet completes, then grant stays 0 while s_tvalid=4'b1111. Re-enabling issues a grant to source 1.
- areset pulsed for 1 cycle mid-packet from source 3 -> m_tvalid=0, grant=0, beats=0 asynchronously. After release, with all sources requesting, the first grant goes to source 0.
